pattern_scan_ctrl: RTL

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

---
 rtl/pattern_scan_ctrl_pkg.sv | 25 ++
 rtl/pattern_bit_det.sv | 50 +++++
 rtl/pattern_scan_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared encodings and constants for the serial pattern scanner.
package pattern_scan_ctrl_pkg;

    localparam int WORD_W   = 8;
    localparam int CNT_W    = 8;
    localparam int PAT_LEN  = 5;
    localparam int BITCNT_W = $clog2(WORD_W + 1);

    localparam logic [PAT_LEN-1:0] PATTERN = 5'b10110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } ctrl_state_t;

    typedef enum logic [2:0] {
        DET_S0,
        DET_S1,
        DET_S2,
        DET_S3,
        DET_S4
    } det_state_t;

endpackage

// File: rtl/pattern_bit_det.sv
// Mealy detector for PATTERN (non-overlapping). The match output is combinational;
// the controller registers it into match_pulse.
module pattern_bit_det
    import pattern_scan_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_valid,
    input  logic bit_in,
    output logic match
);

    det_state_t state_reg, state_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= DET_S0;
        end else begin
            state_reg <= state_next;
        end
    end

    // Each state expects the next pattern bit MSB first; mismatches fall back
    // to the longest prefix still usable.
    always_comb begin
        state_next = state_reg;
        match      = 1'b0;
        if (clr) begin
            state_next = DET_S0;
        end else if (bit_valid) begin
            case (state_reg)
                DET_S0: state_next = (bit_in == PATTERN[4]) ? DET_S1 : DET_S0;
                DET_S1: state_next = (bit_in == PATTERN[3]) ? DET_S2 : DET_S1;
                DET_S2: state_next = (bit_in == PATTERN[2]) ? DET_S3 : DET_S0;
                DET_S3: state_next = (bit_in == PATTERN[1]) ? DET_S4 : DET_S2;
                DET_S4: begin
                    if (bit_in == PATTERN[0]) begin
                        match      = 1'b1;
                        state_next = DET_S0;
                    end else begin
                        state_next = DET_S1;
                    end
                end
                default: state_next = DET_S0;
            endcase
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Job controller: accepts words, serialises them MSB first into the detector,
// counts matches and stops at the latched limit.
module pattern_scan_ctrl
    import pattern_scan_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  match_limit,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              busy,
    output logic              done
);

    ctrl_state_t          state_reg, state_next;
    logic [WORD_W-1:0]    shift_reg, shift_next;
    logic [BITCNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [CNT_W-1:0]     limit_reg, limit_next;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic [CNT_W-1:0]     count_inc;
    logic                 pulse_reg, pulse_next;
    logic                 start_go;
    logic                 accept;
    logic                 bit_valid;
    logic                 det_clr;
    logic                 det_match;

    assign start_go  = start && !abort && (state_reg != ST_RUN);
    assign bit_valid = (state_reg == ST_RUN) && (bit_cnt_reg != '0);
    assign in_ready  = (state_reg == ST_RUN) && (bit_cnt_reg <= BITCNT_W'(1)) && !abort;
    assign accept    = in_valid && in_ready;
    assign det_clr   = start_go || abort;
    assign count_inc = (count_reg == '1) ? count_reg : count_reg + 1'b1;

    pattern_bit_det u_det (
        .clk       (clk),
        .rst       (rst),
        .clr       (det_clr),
        .bit_valid (bit_valid),
        .bit_in    (shift_reg[WORD_W-1]),
        .match     (det_match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            limit_reg   <= '0;
            count_reg   <= '0;
            pulse_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            limit_reg   <= limit_next;
            count_reg   <= count_next;
            pulse_reg   <= pulse_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        limit_next   = limit_reg;
        count_next   = count_reg;
        pulse_next   = 1'b0;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start_go) begin
                    state_next   = ST_RUN;
                    limit_next   = match_limit;
                    count_next   = '0;
                    bit_cnt_next = '0;
                end
            end
            ST_RUN: begin
                if (bit_valid) begin
                    shift_next   = {shift_reg[WORD_W-2:0], 1'b0};
                    bit_cnt_next = bit_cnt_reg - 1'b1;
                end
                // A new word may load on the last-bit cycle of the previous one.
                if (accept) begin
                    shift_next   = in_data;
                    bit_cnt_next = BITCNT_W'(WORD_W);
                end
                if (det_match) begin
                    pulse_next = 1'b1;
                    count_next = count_inc;
                    if ((limit_reg != '0) && (count_inc == limit_reg)) begin
                        state_next   = ST_DONE;
                        bit_cnt_next = '0;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Abort wins over everything, discards the word and freezes the count.
        if (abort) begin
            state_next   = ST_IDLE;
            bit_cnt_next = '0;
            count_next   = count_reg;
            pulse_next   = 1'b0;
        end
    end

    assign match_pulse = pulse_reg;
    assign match_count = count_reg;
    assign busy        = (state_reg == ST_RUN);
    assign done        = (state_reg == ST_DONE);

endmodule
